// File: rtl/rom_arb_pkg.sv
// Shared definitions for the product-image ROM arbiter: owner tags, secondary
// FSM state encodings and default bus widths.
package rom_arb_pkg;

  localparam int unsigned ROM_ADDR_BUS_WIDTH_DEF = 17;
  localparam int unsigned DATA_WIDTH_DEF         = 24;

  typedef logic [1:0] owner_tag_t;
  typedef logic [1:0] sec_state_t;

  localparam owner_tag_t TAG_NONE = 2'd0;
  localparam owner_tag_t TAG_PIX  = 2'd1;
  localparam owner_tag_t TAG_SEC  = 2'd2;

  localparam sec_state_t ST_IDLE     = 2'd0;
  localparam sec_state_t ST_WAIT     = 2'd1;
  localparam sec_state_t ST_INFLIGHT = 2'd2;

endpackage

// File: rtl/rom_owner_pipe.sv
// Owner-tag delay line: carries the issuing owner of each ROM read alongside
// the memory pipeline so returned data can be routed back to its requester.
module rom_owner_pipe
  import rom_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  owner_tag_t tag_i,
  output owner_tag_t tag_o
);

  owner_tag_t pipe_q [DEPTH];

  // Reset flushes every stage so reads in flight at reset never return.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= TAG_NONE;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single-port image ROM between the real-time pixel path (absolute
// priority) and one secondary requester, routing returned words to their owner.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ROM_ADDR_BUS_WIDTH = ROM_ADDR_BUS_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH         = DATA_WIDTH_DEF,
  parameter int unsigned ROM_LATENCY        = 2,
  parameter int unsigned MAX_WAIT           = 1024,
  parameter int unsigned WAIT_CNT_WIDTH     = 11
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          PIX_Active,
  input  logic [ROM_ADDR_BUS_WIDTH-1:0] PIX_Addr,
  output logic [DATA_WIDTH-1:0]         PIX_Data,
  output logic                          PIX_Valid,
  input  logic                          SEC_Req,
  input  logic [ROM_ADDR_BUS_WIDTH-1:0] SEC_Addr,
  output logic                          SEC_Ack,
  output logic [DATA_WIDTH-1:0]         SEC_Data,
  output logic                          SEC_Valid,
  output logic                          SEC_Starved,
  output logic [ROM_ADDR_BUS_WIDTH-1:0] ROM_Addr,
  input  logic [DATA_WIDTH-1:0]         ROM_Data
);

  localparam logic [WAIT_CNT_WIDTH-1:0] MAX_WAIT_C = WAIT_CNT_WIDTH'(MAX_WAIT);

  sec_state_t                    state_q, state_d;
  logic [WAIT_CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic                          starved_q, starved_d;
  logic                          ack_q, ack_d;
  logic [ROM_ADDR_BUS_WIDTH-1:0] addr_q, addr_d;
  owner_tag_t                    tag_q, tag_d;
  owner_tag_t                    tag_aligned;
  logic [DATA_WIDTH-1:0]         pix_data_q, sec_data_q;
  logic                          pix_valid_q, sec_valid_q;

  // The issued tag is registered with ROM_Addr, so the pipe output lines up
  // with ROM_Data one edge after the ROM latency has elapsed.
  rom_owner_pipe #(
    .DEPTH (ROM_LATENCY)
  ) u_owner_pipe (
    .clk_i (CLK),
    .rst_i (RST),
    .tag_i (tag_q),
    .tag_o (tag_aligned)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    starved_d = starved_q;
    ack_d     = 1'b0;
    addr_d    = '0;
    tag_d     = TAG_NONE;

    if (PIX_Active) begin
      addr_d = PIX_Addr;
      tag_d  = TAG_PIX;
      if (state_q == ST_IDLE && SEC_Req) begin
        state_d   = ST_WAIT;
        cnt_d     = '0;
        starved_d = 1'b0;
      end else if (state_q == ST_WAIT) begin
        if (SEC_Req) begin
          cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          starved_d = (cnt_d >= MAX_WAIT_C);
        end else begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          starved_d = 1'b0;
        end
      end
    end else if (SEC_Req && state_q != ST_INFLIGHT) begin
      addr_d    = SEC_Addr;
      tag_d     = TAG_SEC;
      ack_d     = 1'b1;
      state_d   = ST_INFLIGHT;
      cnt_d     = '0;
      starved_d = 1'b0;
    end else if (state_q == ST_WAIT) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      starved_d = 1'b0;
    end

    // The FSM is already IDLE during the SEC_Valid cycle.
    if (state_q == ST_INFLIGHT && tag_aligned == TAG_SEC) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      starved_q   <= 1'b0;
      ack_q       <= 1'b0;
      addr_q      <= '0;
      tag_q       <= TAG_NONE;
      pix_data_q  <= '0;
      sec_data_q  <= '0;
      pix_valid_q <= 1'b0;
      sec_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starved_q   <= starved_d;
      ack_q       <= ack_d;
      addr_q      <= addr_d;
      tag_q       <= tag_d;
      pix_valid_q <= (tag_aligned == TAG_PIX);
      sec_valid_q <= (tag_aligned == TAG_SEC);
      if (tag_aligned == TAG_PIX) begin
        pix_data_q <= ROM_Data;
      end
      if (tag_aligned == TAG_SEC) begin
        sec_data_q <= ROM_Data;
      end
    end
  end

  assign ROM_Addr    = addr_q;
  assign SEC_Ack     = ack_q;
  assign SEC_Starved = starved_q;
  assign PIX_Data    = pix_data_q;
  assign PIX_Valid   = pix_valid_q;
  assign SEC_Data    = sec_data_q;
  assign SEC_Valid   = sec_valid_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed scenarios plus random traffic, checked
// against a cycle-scheduled reference model of the arbitration rules.
module tb_rom_port_arbiter;

  localparam int AW = 17;
  localparam int DW = 24;
  localparam int MW = 16;
  localparam int LAT_EDGES = 3;  // issue edge to Valid edge (ROM latency 2 + 1)

  logic          CLK = 1'b0;
  logic          RST;
  logic          PIX_Active;
  logic [AW-1:0] PIX_Addr;
  logic [DW-1:0] PIX_Data;
  logic          PIX_Valid;
  logic          SEC_Req;
  logic [AW-1:0] SEC_Addr;
  logic          SEC_Ack;
  logic [DW-1:0] SEC_Data;
  logic          SEC_Valid;
  logic          SEC_Starved;
  logic [AW-1:0] ROM_Addr;
  logic [DW-1:0] ROM_Data;
  logic [AW-1:0] rom_a1;

  int tests = 0;
  int fails = 0;

  rom_port_arbiter #(
    .ROM_ADDR_BUS_WIDTH (AW),
    .DATA_WIDTH         (DW),
    .ROM_LATENCY        (2),
    .MAX_WAIT           (MW),
    .WAIT_CNT_WIDTH     (11)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .PIX_Active  (PIX_Active),
    .PIX_Addr    (PIX_Addr),
    .PIX_Data    (PIX_Data),
    .PIX_Valid   (PIX_Valid),
    .SEC_Req     (SEC_Req),
    .SEC_Addr    (SEC_Addr),
    .SEC_Ack     (SEC_Ack),
    .SEC_Data    (SEC_Data),
    .SEC_Valid   (SEC_Valid),
    .SEC_Starved (SEC_Starved),
    .ROM_Addr    (ROM_Addr),
    .ROM_Data    (ROM_Data)
  );

  always #5 CLK = ~CLK;

  // Two-cycle ROM returning {7'b0, addr}.
  always @(posedge CLK) begin
    rom_a1   <= ROM_Addr;
    ROM_Data <= {7'b0, rom_a1};
  end

  // Reference model: reads are scheduled into a slot LAT_EDGES edges ahead.
  int n_edge;
  int sched_kind [8];
  int sched_addr [8];
  int sec_free_edge;
  bit waiting;
  int waited;
  bit m_starved, m_ack, m_pv, m_sv;
  int m_rom_addr, m_pd, m_sd;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      sched_kind[i] = 0;
      sched_addr[i] = 0;
    end
    sec_free_edge = n_edge;
    waiting = 0; waited = 0;
    m_starved = 0; m_ack = 0; m_pv = 0; m_sv = 0;
    m_rom_addr = 0; m_pd = 0; m_sd = 0;
  endfunction

  function automatic void model_edge(bit pa, int paddr, bit sr, int saddr);
    int slot, kind, ikind, iaddr;
    bit busy;
    n_edge++;
    slot = n_edge % 8;
    kind = sched_kind[slot];
    sched_kind[slot] = 0;
    m_pv = (kind == 1);
    m_sv = (kind == 2);
    if (m_pv) m_pd = sched_addr[slot];
    if (m_sv) m_sd = sched_addr[slot];
    busy  = (n_edge < sec_free_edge);
    m_ack = 0;
    ikind = 0; iaddr = 0;
    if (pa) begin
      ikind = 1; iaddr = paddr;
      if (!busy) begin
        if (sr) begin
          waited  = waiting ? ((waited < 2047) ? waited + 1 : 2047) : 0;
          waiting = 1;
          m_starved = (waited >= MW);
        end else begin
          waiting = 0; waited = 0; m_starved = 0;
        end
      end
    end else if (sr && !busy) begin
      ikind = 2; iaddr = saddr;
      m_ack = 1;
      sec_free_edge = n_edge + LAT_EDGES + 1;
      waiting = 0; waited = 0; m_starved = 0;
    end else if (!busy) begin
      waiting = 0; waited = 0; m_starved = 0;
    end
    sched_kind[(n_edge + LAT_EDGES) % 8] = ikind;
    sched_addr[(n_edge + LAT_EDGES) % 8] = iaddr;
    m_rom_addr = iaddr;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rom_addr",    32'(ROM_Addr),    32'(m_rom_addr));
    chk("sec_ack",     32'(SEC_Ack),     32'(m_ack));
    chk("sec_starved", 32'(SEC_Starved), 32'(m_starved));
    chk("pix_valid",   32'(PIX_Valid),   32'(m_pv));
    chk("pix_data",    32'(PIX_Data),    32'(m_pd));
    chk("sec_valid",   32'(SEC_Valid),   32'(m_sv));
    chk("sec_data",    32'(SEC_Data),    32'(m_sd));
  endtask

  // Called from #1 after an edge: drive, take one edge, compare.
  task automatic step(input bit pa, input int paddr, input bit sr, input int saddr);
    PIX_Active = pa;
    PIX_Addr   = AW'(paddr);
    SEC_Req    = sr;
    SEC_Addr   = AW'(saddr);
    @(posedge CLK);
    model_edge(pa, paddr, sr, saddr);
    #1;
    check_all();
  endtask

  int pa_run, pa_val, sr_r, sa_r, caddr;

  initial begin
    RST = 1'b1;
    PIX_Active = 0; PIX_Addr = '0; SEC_Req = 0; SEC_Addr = '0;
    n_edge = 0;
    model_reset();
    @(posedge CLK);
    #1;
    check_all();
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Pixel burst, addresses 0..99, then drain.
    for (int i = 0; i < 100; i++) step(1, i, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("burst_last_pix", 32'(PIX_Data), 32'd99);

    // Idle secondary request.
    step(0, 0, 1, 'h1F000);
    chk("idle_sec_ack", 32'(SEC_Ack), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("idle_sec_data", 32'(SEC_Data), 32'h01F000);

    // Contention: pixel holds the ROM for 40 cycles.
    caddr = 'h0ABCD;
    for (int i = 0; i < 40; i++) step(1, 200 + i, 1, caddr);
    chk("cont_no_ack", 32'(SEC_Ack), 32'd0);
    step(0, 0, 1, caddr);
    chk("cont_ack", 32'(SEC_Ack), 32'd1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("cont_sec_data", 32'(SEC_Data), 32'h00ABCD);

    // Starvation with 30 pixel cycles pending.
    for (int i = 0; i < 30; i++) step(1, 300 + i, 1, 'h12345);
    chk("starved_set", 32'(SEC_Starved), 32'd1);
    step(0, 0, 1, 'h12345);
    chk("starved_clr", 32'(SEC_Starved), 32'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);

    // Reset with a secondary and a pixel read in flight.
    step(0, 0, 1, 'h00777);
    step(1, 'h00555, 0, 0);
    RST = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    chk("flush_sec_data", 32'(SEC_Data), 32'd0);

    // Random traffic with a protocol-abiding requester.
    pa_run = 0; pa_val = 0; sr_r = 0; sa_r = 0;
    for (int i = 0; i < 800; i++) begin
      if (pa_run == 0) begin
        pa_val = ($urandom_range(0, 99) < 55) ? 1 : 0;
        pa_run = int'($urandom_range(1, 24));
      end
      pa_run--;
      if (sr_r == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          sr_r = 1;
          sa_r = int'($urandom_range(0, (1 << AW) - 1));
        end
      end else if (m_ack) begin
        if ($urandom_range(0, 1) == 0) sr_r = 0;
        else sa_r = int'($urandom_range(0, (1 << AW) - 1));
      end else if ($urandom_range(0, 31) == 0) begin
        sr_r = 0;
      end
      step(pa_val[0], int'($urandom_range(0, (1 << AW) - 1)), sr_r[0], sa_r);
    end
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
